init_reset_sequencer: RTL and testbench

Power-up reset sequencer that consumes the PolarFire init-monitor status outputs, a fabric PLL lock and the DDR controller ready flag, and releases the design's reset domains in order: fabric logic and DDR first, then the RISC-V core and the UART-to-SPI bridge. It sits directly below the top level, between the init monitor and every reset input in the design. It replaces ad-hoc AND-gating of done flags with a deterministic, timeout-guarded state machine.

---
 rtl/init_reset_sequencer.sv | 173 +++++++++++++++++
 tb/tb_init_reset_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/init_reset_sequencer.sv
// Power-up reset sequencer: synchronizes init-monitor, PLL and DDR status, then releases
// fabric/DDR reset followed by core/bridge reset, guarded by a lock window and DDR timeout.
//
// state     | meaning
// IDLE      | one-cycle start after reset or retry
// WAIT_INIT | waiting for POR, device init and I/O calibration done
// WAIT_LOCK | qualifying PLL lock for LOCK_CYCLES consecutive cycles
// DDR_REL   | fabric and DDR released, settling delay
// WAIT_DDR  | waiting for DDR ready, bounded by DDR_TIMEOUT
// CPU_REL   | DDR ready seen, delay before core release
// RUN       | all domains released
// FAULT     | DDR timed out; all resets asserted until RETRY
module init_reset_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int LOCK_CYCLES   = 16,
  parameter int RELEASE_DELAY = 8,
  parameter int DDR_TIMEOUT   = 1048576,
  parameter int CNT_W         = 21
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       FABRIC_POR_N,
  input  logic       DEVICE_INIT_DONE,
  input  logic       AUTOCALIB_DONE,
  input  logic       PLL_LOCK,
  input  logic       DDR_READY,
  input  logic       RETRY,
  output logic       FABRIC_RESET_N,
  output logic       DDR_RESET_N,
  output logic       CPU_RESET_N,
  output logic       INIT_DONE,
  output logic       INIT_FAULT,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_INIT = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_DDR_REL   = 3'd3,
    S_WAIT_DDR  = 3'd4,
    S_CPU_REL   = 3'd5,
    S_RUN       = 3'd6,
    S_FAULT     = 3'd7
  } state_e;

  localparam logic [CNT_W-1:0] LOCK_TC = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_TC  = CNT_W'(RELEASE_DELAY - 1);
  localparam logic [CNT_W-1:0] TMO_TC  = CNT_W'(DDR_TIMEOUT - 1);

  // bit order: {DDR_READY, PLL_LOCK, AUTOCALIB_DONE, DEVICE_INIT_DONE, FABRIC_POR_N}
  logic [4:0] sync_q [SYNC_STAGES];
  logic       por_s, init_s, cal_s, lock_s, ddr_rdy_s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             rel_d, run_d, fault_d;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {DDR_READY, PLL_LOCK, AUTOCALIB_DONE, DEVICE_INIT_DONE, FABRIC_POR_N};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign por_s     = sync_q[SYNC_STAGES-1][0];
  assign init_s    = sync_q[SYNC_STAGES-1][1];
  assign cal_s     = sync_q[SYNC_STAGES-1][2];
  assign lock_s    = sync_q[SYNC_STAGES-1][3];
  assign ddr_rdy_s = sync_q[SYNC_STAGES-1][4];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + CNT_W'(1);
    case (state_q)
      S_IDLE: begin
        state_d = S_WAIT_INIT;
        cnt_d   = '0;
      end
      S_WAIT_INIT: begin
        cnt_d = '0;
        if (por_s && init_s && cal_s) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (!lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_TC) begin
          state_d = S_DDR_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DDR_REL: begin
        if (cnt_q == REL_TC) begin
          state_d = S_WAIT_DDR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT_DDR: begin
        // ready is checked first so it beats a same-cycle timeout
        if (ddr_rdy_s) begin
          state_d = S_CPU_REL;
          cnt_d   = '0;
        end else if (cnt_q == TMO_TC) begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_CPU_REL: begin
        if (cnt_q == REL_TC) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      S_FAULT: begin
        if (RETRY) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (!por_s && state_q != S_IDLE && state_q != S_WAIT_INIT) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (!lock_s && state_q inside {S_DDR_REL, S_WAIT_DDR, S_CPU_REL, S_RUN}) begin
      state_d = S_WAIT_LOCK;
      cnt_d   = '0;
    end

    rel_d   = state_d inside {S_DDR_REL, S_WAIT_DDR, S_CPU_REL, S_RUN};
    run_d   = (state_d == S_RUN);
    fault_d = (state_d == S_FAULT);
  end

  // outputs decode the next state so they move on the same edge as STATE
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      FABRIC_RESET_N <= 1'b0;
      DDR_RESET_N    <= 1'b0;
      CPU_RESET_N    <= 1'b0;
      INIT_DONE      <= 1'b0;
      INIT_FAULT     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      FABRIC_RESET_N <= rel_d;
      DDR_RESET_N    <= rel_d;
      CPU_RESET_N    <= run_d;
      INIT_DONE      <= run_d;
      INIT_FAULT     <= fault_d;
    end
  end

  assign STATE = state_q;

endmodule

// File: tb/tb_init_reset_sequencer.sv
// Bench for init_reset_sequencer: a timestamp-based reference model predicts every output
// change; a monitor matches observed changes against that queue. Directed latencies on top.
module tb_init_reset_sequencer;

  localparam int SS = 2;
  localparam int LC = 16;
  localparam int RD = 8;
  localparam int TO = 1024;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       por = 1'b0, init = 1'b0, cal = 1'b0, lock = 1'b0, rdy = 1'b0, retry = 1'b0;
  logic       fab_n, ddr_n, cpu_n, done, fault;
  logic [2:0] state;

  init_reset_sequencer #(
    .SYNC_STAGES(SS), .LOCK_CYCLES(LC), .RELEASE_DELAY(RD), .DDR_TIMEOUT(TO), .CNT_W(21)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .FABRIC_POR_N(por), .DEVICE_INIT_DONE(init), .AUTOCALIB_DONE(cal),
    .PLL_LOCK(lock), .DDR_READY(rdy), .RETRY(retry),
    .FABRIC_RESET_N(fab_n), .DDR_RESET_N(ddr_n), .CPU_RESET_N(cpu_n),
    .INIT_DONE(done), .INIT_FAULT(fault), .STATE(state)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] phase_vec(input int ph);
    logic rel, run;
    rel = (ph >= 3 && ph <= 6);
    run = (ph == 6);
    return {3'(ph), rel, rel, run, run, (ph == 7)};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {state, fab_n, ddr_n, cpu_n, done, fault};
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  vec;
  } ev_t;

  ev_t        exp_q[$];
  int         cyc = 0;
  int         ph = 0, enter = 0, run_len = 0;
  logic [4:0] hist[$];
  logic [7:0] last_exp = 8'h00;

  initial for (int i = 0; i < SS; i++) hist.push_back(5'b0);

  always @(posedge CLK) begin
    logic [4:0] s;
    int         nph;
    logic [7:0] v;
    ev_t        e;
    cyc++;
    if (RESET) begin
      hist.delete();
      for (int i = 0; i < SS; i++) hist.push_back(5'b0);
      ph = 0; enter = cyc; run_len = 0;
    end else begin
      // s = raw inputs as they were SS edges ago: {rdy, lock, cal, init, por}
      s = hist[0];
      hist.push_back({rdy, lock, cal, init, por});
      void'(hist.pop_front());
      nph = ph;
      case (ph)
        0: nph = 1;
        1: if (s[0] && s[1] && s[2]) nph = 2;
        2: begin
          run_len = s[3] ? run_len + 1 : 0;
          if (run_len == LC) nph = 3;
        end
        3: if (cyc - enter == RD) nph = 4;
        4: if (s[4]) nph = 5; else if (cyc - enter == TO) nph = 7;
        5: if (cyc - enter == RD) nph = 6;
        7: if (retry) nph = 0;
        default: nph = ph;
      endcase
      if (!s[0] && ph > 1) nph = 0;
      else if (!s[3] && ph >= 3 && ph <= 6) nph = 2;
      if (nph != ph) begin
        ph = nph; enter = cyc; run_len = 0;
      end
    end
    v = phase_vec(ph);
    if (v != last_exp) begin
      e.cyc = cyc;
      e.vec = v;
      exp_q.push_back(e);
    end
    last_exp = v;
  end

  // ---------------- monitor ----------------
  bit         mon_en = 0;
  logic [7:0] last_dut = 8'h00;

  always @(negedge CLK) begin
    logic [7:0] v;
    ev_t        e;
    if (mon_en) begin
      v = dut_vec();
      while (exp_q.size() > 0 && int'(exp_q[0].cyc) < cyc) begin
        e = exp_q.pop_front();
        check("missed_change_cycle", cyc, e.cyc);
      end
      if (v !== last_dut) begin
        if (exp_q.size() == 0) begin
          check("unexpected_change", v, last_dut);
        end else begin
          e = exp_q.pop_front();
          check("change_cycle", cyc, e.cyc);
          check("change_outputs", v, e.vec);
        end
        last_dut = v;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name,
                            output int edges);
    edges = 0;
    while (state !== s && edges < budget) begin
      @(negedge CLK);
      edges++;
    end
    if (state !== s) check({name, "_timeout"}, state, s);
  endtask

  task automatic to_wait_lock_and_back();
    int e;
    lock = 1'b0;
    wait_state(3'd2, 10, "drop_to_wait_lock", e);
    cycles($urandom_range(1, 4));
    lock = 1'b1;
  endtask

  initial begin
    int e;
    cycles(3);
    check("reset_outputs", dut_vec(), 8'h00);
    RESET = 1'b0;
    last_dut = dut_vec();
    mon_en = 1;

    // nominal bring-up
    cycles($urandom_range(1, 5));
    por = 1'b1; init = 1'b1; cal = 1'b1;
    wait_state(3'd2, 50, "reach_wait_lock", e);
    cycles($urandom_range(0, 4));
    lock = 1'b1;
    wait_state(3'd3, 40, "reach_ddr_rel", e);
    check("lock_to_ddr_release", e, SS + LC);
    check("ddr_reset_n_up", ddr_n, 1'b1);
    wait_state(3'd4, 20, "reach_wait_ddr", e);
    check("ddr_release_to_wait_ddr", e, RD);
    cycles(42);
    rdy = 1'b1;
    wait_state(3'd6, 40, "reach_run", e);
    check("ddr_ready_to_cpu_release", e, SS + 1 + RD);
    check("run_outputs", dut_vec(), 8'b110_11110);

    // RETRY and DDR_READY drop are ignored in RUN
    retry = 1'b1; cycles(1); retry = 1'b0;
    rdy = 1'b0;
    cycles(6);
    check("run_holds", state, 3'd6);
    rdy = 1'b1;

    // lock loss in RUN, then replay
    lock = 1'b0;
    wait_state(3'd2, 10, "lock_loss", e);
    check("lock_loss_outputs", dut_vec(), 8'b010_00000);
    cycles(3);
    lock = 1'b1;
    wait_state(3'd6, 100, "replay_run", e);

    // lock glitch inside WAIT_LOCK
    lock = 1'b0;
    wait_state(3'd2, 10, "glitch_setup", e);
    cycles(4);
    lock = 1'b1; cycles(10);
    lock = 1'b0; cycles(1);
    lock = 1'b1;
    wait_state(3'd3, 40, "glitch_release", e);
    check("glitch_release_latency", e, SS + LC);
    wait_state(3'd6, 100, "glitch_run", e);

    // POR loss beats lock loss
    por = 1'b0; lock = 1'b0;
    e = 0;
    while (state === 3'd6 && e < 10) begin
      @(negedge CLK);
      e++;
    end
    check("por_priority_state", state, 3'd0);
    por = 1'b1; lock = 1'b1;
    wait_state(3'd6, 100, "por_replay_run", e);

    // DDR timeout, then RETRY
    rdy = 1'b0;
    to_wait_lock_and_back();
    wait_state(3'd4, 60, "timeout_wait_ddr", e);
    wait_state(3'd7, TO + 10, "reach_fault", e);
    check("ddr_timeout_latency", e, TO);
    check("fault_outputs", dut_vec(), 8'b111_00001);
    cycles($urandom_range(1, 5));
    retry = 1'b1; cycles(1); retry = 1'b0;
    check("retry_to_idle", state, 3'd0);
    wait_state(3'd4, 60, "retry_wait_ddr", e);
    cycles($urandom_range(2, 20));
    rdy = 1'b1;
    wait_state(3'd6, 40, "retry_run", e);

    // RESET pulse in WAIT_DDR
    rdy = 1'b0;
    to_wait_lock_and_back();
    wait_state(3'd4, 60, "reset_wait_ddr", e);
    cycles(3);
    RESET = 1'b1; cycles(1); RESET = 1'b0;
    check("reset_midseq_outputs", dut_vec(), 8'h00);
    rdy = 1'b1;
    wait_state(3'd6, 100, "reset_replay_run", e);

    // randomized churn, judged by the model only
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) por  = ~por;
      if ($urandom_range(0, 59) == 0) init = ~init;
      if ($urandom_range(0, 59) == 0) cal  = ~cal;
      if ($urandom_range(0, 39) == 0) lock = ~lock;
      if ($urandom_range(0, 49) == 0) rdy  = ~rdy;
      retry = ($urandom_range(0, 29) == 0);
      RESET = ($urandom_range(0, 499) == 0);
      if (i % 400 == 399) begin
        por = 1'b1; init = 1'b1; cal = 1'b1; lock = 1'b1;
      end
      cycles(1);
    end
    RESET = 1'b0; retry = 1'b0;
    cycles(8);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
